// File: rtl/guess_game_ctrl.sv
// Guessing-game round controller: draws a secret in -99..+99 from the PRNG stream by
// rejection sampling, then grades sign-magnitude guesses and counts attempts.
module guess_game_ctrl #(
  parameter int MAX_TRIES = 7,
  parameter int MAX_DRAW  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] prn,
  input  logic       new_game,
  input  logic       guess_valid,
  input  logic [7:0] guess,
  output logic       ready,
  output logic       too_high,
  output logic       too_low,
  output logic       correct,
  output logic       bad_guess,
  output logic       game_over,
  output logic [7:0] attempts,
  output logic [7:0] secret
);

  typedef enum logic [2:0] {IDLE, DRAW, PLAY, WON, LOST} state_t;

  localparam logic [7:0] DRAW_LAST = 8'(MAX_DRAW - 1);
  localparam logic [8:0] TRIES_LAST = 9'(MAX_TRIES);

  state_t     state, state_n;
  logic [7:0] draw_cnt, draw_cnt_n;
  logic [7:0] secret_n, attempts_n;
  logic       too_high_n, too_low_n, correct_n, bad_guess_n;
  logic       prn_ok;
  logic [7:0] prn_fold;
  logic [7:0] guess_tc, secret_tc;

  // Sign-magnitude to two's complement; -0 maps naturally to 0.
  function automatic logic [7:0] to_tc(input logic [7:0] sm);
    return sm[7] ? (8'd0 - {1'b0, sm[6:0]}) : {1'b0, sm[6:0]};
  endfunction

  assign prn_ok    = (prn[6:0] <= 7'd99) && (prn != 8'h80);
  assign prn_fold  = (prn[6:0] >= 7'd100) ? {prn[7], prn[6:0] - 7'd100} : 8'h00;
  assign guess_tc  = to_tc(guess);
  assign secret_tc = to_tc(secret);

  always_comb begin
    state_n     = state;
    draw_cnt_n  = draw_cnt;
    secret_n    = secret;
    attempts_n  = attempts;
    too_high_n  = too_high;
    too_low_n   = too_low;
    correct_n   = correct;
    bad_guess_n = 1'b0;

    if (new_game) begin
      state_n    = DRAW;
      draw_cnt_n = 8'd0;
      secret_n   = 8'd0;
      attempts_n = 8'd0;
      too_high_n = 1'b0;
      too_low_n  = 1'b0;
      correct_n  = 1'b0;
    end else begin
      case (state)
        DRAW: begin
          if (prn_ok) begin
            secret_n = prn;
            state_n  = PLAY;
          end else if (draw_cnt == DRAW_LAST) begin
            // Out of draw budget: fold the rejected sample into range instead.
            secret_n = prn_fold;
            state_n  = PLAY;
          end else begin
            draw_cnt_n = draw_cnt + 8'd1;
          end
        end
        PLAY: begin
          if (guess_valid) begin
            if (guess[6:0] > 7'd99) begin
              bad_guess_n = 1'b1;
            end else begin
              attempts_n = (attempts == 8'hFF) ? attempts : attempts + 8'd1;
              too_high_n = $signed(guess_tc) > $signed(secret_tc);
              too_low_n  = $signed(guess_tc) < $signed(secret_tc);
              correct_n  = guess_tc == secret_tc;
              if (guess_tc == secret_tc)
                state_n = WON;
              else if (({1'b0, attempts} + 9'd1) == TRIES_LAST)
                state_n = LOST;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      draw_cnt  <= 8'd0;
      secret    <= 8'd0;
      attempts  <= 8'd0;
      too_high  <= 1'b0;
      too_low   <= 1'b0;
      correct   <= 1'b0;
      bad_guess <= 1'b0;
      ready     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      draw_cnt  <= draw_cnt_n;
      secret    <= secret_n;
      attempts  <= attempts_n;
      too_high  <= too_high_n;
      too_low   <= too_low_n;
      correct   <= correct_n;
      bad_guess <= bad_guess_n;
      ready     <= (state_n == PLAY);
      game_over <= (state_n == WON) || (state_n == LOST);
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed testbench for guess_game_ctrl: draw/reject/fold, grading, win/loss and reset paths.
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] prn;
  logic       new_game;
  logic       guess_valid;
  logic [7:0] guess;
  logic       ready, too_high, too_low, correct, bad_guess, game_over;
  logic [7:0] attempts, secret;
  logic [5:0] status;

  int checks = 0;
  int fails  = 0;

  guess_game_ctrl #(.MAX_TRIES(7), .MAX_DRAW(16)) dut (
    .clk(clk), .reset(reset), .prn(prn), .new_game(new_game),
    .guess_valid(guess_valid), .guess(guess), .ready(ready),
    .too_high(too_high), .too_low(too_low), .correct(correct),
    .bad_guess(bad_guess), .game_over(game_over),
    .attempts(attempts), .secret(secret)
  );

  always #5 clk = ~clk;

  // {ready, too_high, too_low, correct, bad_guess, game_over}
  assign status = {ready, too_high, too_low, correct, bad_guess, game_over};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [7:0] p);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    prn = p;
    tick();
  endtask

  task automatic do_guess(input logic [7:0] g);
    guess_valid = 1'b1;
    guess = g;
    tick();
    guess_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; prn = 8'hFF; new_game = 1'b0; guess_valid = 1'b0; guess = 8'h00;
    #12;
    checks++;
    if (status !== 6'b0 || attempts !== 8'd0 || secret !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: got status=%b att=%0d sec=%h want 0/0/0", status, attempts, secret);
    end
    reset = 1'b0;
    tick();
    new_game = 1'b1; prn = 8'hFF;
    tick();
    new_game = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (status !== 6'b0 || secret !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_draw: got status=%b sec=%h want 0/00", status, secret);
    end
    #3 reset = 1'b0;
    prn = 8'h05;
    tick(); tick(); tick();
    checks++;
    if (ready !== 1'b0 || secret !== 8'd0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got ready=%b sec=%h want 0/00", ready, secret);
    end
  endtask

  task automatic test_draw_reject();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    checks++;
    if (ready !== 1'b0 || secret !== 8'd0) begin
      fails++;
      $display("[TB] FAIL draw_entry: got ready=%b sec=%h want 0/00", ready, secret);
    end
    prn = 8'h7F;
    tick();
    prn = 8'h80;
    tick();
    checks++;
    if (ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL draw_rejects: got ready=%b want 0", ready);
    end
    prn = 8'hA5;
    tick();
    checks++;
    if (status !== 6'b100000 || secret !== 8'hA5 || attempts !== 8'd0) begin
      fails++;
      $display("[TB] FAIL draw_accept: got status=%b sec=%h att=%0d want 100000/a5/0", status, secret, attempts);
    end
  endtask

  task automatic test_fold();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    prn = 8'hF0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL fold_wait: draw cycle %0d got ready=%b want 0", i, ready);
      end
    end
    tick();
    checks++;
    if (ready !== 1'b1 || secret !== 8'h8C) begin
      fails++;
      $display("[TB] FAIL fold_accept: got ready=%b sec=%h want 1/8c", ready, secret);
    end
  endtask

  task automatic test_grading();
    start_round(8'h05);
    checks++;
    if (ready !== 1'b1 || secret !== 8'h05) begin
      fails++;
      $display("[TB] FAIL grade_start: got ready=%b sec=%h want 1/05", ready, secret);
    end
    do_guess(8'h85);
    checks++;
    if (status !== 6'b101000 || attempts !== 8'd1) begin
      fails++;
      $display("[TB] FAIL grade_low: got status=%b att=%0d want 101000/1", status, attempts);
    end
    do_guess(8'h32);
    checks++;
    if (status !== 6'b110000 || attempts !== 8'd2) begin
      fails++;
      $display("[TB] FAIL grade_high: got status=%b att=%0d want 110000/2", status, attempts);
    end
    do_guess(8'h05);
    checks++;
    if (status !== 6'b000101 || attempts !== 8'd3) begin
      fails++;
      $display("[TB] FAIL grade_won: got status=%b att=%0d want 000101/3", status, attempts);
    end
    do_guess(8'h00);
    tick();
    checks++;
    if (status !== 6'b000101 || attempts !== 8'd3) begin
      fails++;
      $display("[TB] FAIL won_hold: got status=%b att=%0d want 000101/3", status, attempts);
    end
  endtask

  task automatic test_lost();
    logic [7:0] g [7];
    logic [5:0] exp_st [7];
    g      = '{8'h80, 8'h63, 8'hE3, 8'h09, 8'h0B, 8'h8A, 8'h01};
    exp_st = '{6'b101000, 6'b110000, 6'b101000, 6'b101000, 6'b110000, 6'b101000, 6'b001001};
    start_round(8'h0A);
    do_guess(8'h64);
    checks++;
    if (status !== 6'b100010 || attempts !== 8'd0) begin
      fails++;
      $display("[TB] FAIL bad_guess: got status=%b att=%0d want 100010/0", status, attempts);
    end
    tick();
    checks++;
    if (status !== 6'b100000) begin
      fails++;
      $display("[TB] FAIL bad_guess_pulse: got status=%b want 100000", status);
    end
    for (int i = 0; i < 7; i++) begin
      do_guess(g[i]);
      checks++;
      if (status !== exp_st[i] || attempts !== 8'(i + 1)) begin
        fails++;
        $display("[TB] FAIL lost_seq[%0d]: got status=%b att=%0d want %b/%0d", i, status, attempts, exp_st[i], i + 1);
      end
    end
    do_guess(8'h0A);
    checks++;
    if (status !== 6'b001001 || attempts !== 8'd7) begin
      fails++;
      $display("[TB] FAIL lost_hold: got status=%b att=%0d want 001001/7", status, attempts);
    end
  endtask

  task automatic test_last_try_win();
    start_round(8'h85);
    for (int i = 0; i < 6; i++) do_guess(8'h00);
    checks++;
    if (status !== 6'b110000 || attempts !== 8'd6) begin
      fails++;
      $display("[TB] FAIL six_wrong: got status=%b att=%0d want 110000/6", status, attempts);
    end
    do_guess(8'h85);
    checks++;
    if (status !== 6'b000101 || attempts !== 8'd7) begin
      fails++;
      $display("[TB] FAIL last_try_win: got status=%b att=%0d want 000101/7", status, attempts);
    end
  endtask

  task automatic test_back_to_back();
    start_round(8'h0A);
    do_guess(8'h00);
    do_guess(8'h00);
    new_game = 1'b1; guess_valid = 1'b1; guess = 8'h0A; prn = 8'hFF;
    tick();
    new_game = 1'b0; guess_valid = 1'b0;
    checks++;
    if (status !== 6'b0 || attempts !== 8'd0 || secret !== 8'd0) begin
      fails++;
      $display("[TB] FAIL newgame_priority: got status=%b att=%0d sec=%h want 0/0/00", status, attempts, secret);
    end
    tick();
    prn = 8'h12;
    tick();
    checks++;
    if (status !== 6'b100000 || secret !== 8'h12 || attempts !== 8'd0) begin
      fails++;
      $display("[TB] FAIL restart_draw: got status=%b sec=%h att=%0d want 100000/12/0", status, secret, attempts);
    end
  endtask

  task automatic test_reset_play();
    do_guess(8'h00);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (status !== 6'b0 || attempts !== 8'd0 || secret !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_play: got status=%b att=%0d sec=%h want 0/0/00", status, attempts, secret);
    end
    #3 reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_draw_reject();
    test_fold();
    test_grading();
    test_lost();
    test_last_try_win();
    test_back_to_back();
    test_reset_play();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
